// File: rtl/ifu32_fetch.sv
// ifu32_fetch: instruction fetch unit for the GPC32 core.
// Owns the fetch PC, issues in-order word requests, buffers returned words with
// their PC in a DEPTH-entry FIFO and hands them to decode over valid/ready.
// A redirect flushes the FIFO and drops responses still in flight.
// Optional feature macro: IFU32_BYPASS_EN -- when defined, a response arriving
// while the FIFO is empty is presented to decode combinationally in the same cycle.
module ifu32_fetch #(
  parameter int               INST_MAX = 32,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_START = 32'h8000_0000,
  parameter int               DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [WIDTH-1:0]    redirect_pc,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [WIDTH-1:0]    mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [INST_MAX-1:0] mem_rsp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_MAX-1:0] inst,
  output logic [WIDTH-1:0]    inst_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_W  = CW'(DEPTH);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] fpc_q, fpc_d;     // next address to request
  logic [WIDTH-1:0] rpc_q, rpc_d;     // PC of the next kept response
  logic [CW-1:0]    infl_q, infl_d;   // requests accepted, response not yet seen
  logic [CW-1:0]    drop_q, drop_d;   // stale responses still to discard
  logic [CW-1:0]    cnt_q, cnt_d;     // FIFO occupancy
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;

  logic [DEPTH-1:0][INST_MAX-1:0] fifo_data_q;
  logic [DEPTH-1:0][WIDTH-1:0]    fifo_pc_q;

  logic req_fire, rsp_keep, head_valid, push, pop;
  logic [INST_MAX-1:0] head_inst;
  logic [WIDTH-1:0]    head_pc;

  // Credit check counts words in flight plus words buffered; a same-cycle pop
  // is deliberately not credited so the request path never sees inst_ready.
  assign mem_req_valid = rst && (state_q == S_FETCH) &&
                         (({1'b0, infl_q} + {1'b0, cnt_q}) < DEPTH_W);
  assign mem_req_addr  = fpc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response is kept only when nothing stale is pending and no redirect is
  // killing it in this very cycle.
  assign rsp_keep   = mem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign head_valid = (cnt_q != '0);
  assign head_inst  = head_valid ? fifo_data_q[rp_q] : '0;
  assign head_pc    = head_valid ? fifo_pc_q[rp_q]   : '0;
  assign pop        = head_valid && inst_ready;

`ifdef IFU32_BYPASS_EN
  logic byp;
  // Empty FIFO: forward the arriving word straight to decode.
  assign byp        = rst && rsp_keep && !head_valid;
  assign inst_valid = head_valid || byp;
  assign inst       = head_valid ? head_inst : (byp ? mem_rsp_data : '0);
  assign inst_pc    = head_valid ? head_pc   : (byp ? rpc_q : '0);
  assign push       = rsp_keep && !(byp && inst_ready);
`else
  assign inst_valid = head_valid;
  assign inst       = head_inst;
  assign inst_pc    = head_pc;
  assign push       = rsp_keep;
`endif

  // Next-state: counters, pointers, PCs and the FETCH/FLUSH machine.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    drop_d  = drop_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    infl_d  = infl_q + CW'(req_fire) - CW'(mem_rsp_valid);
    if (redirect_valid) begin
      // Everything in flight after this edge is stale, including a request
      // firing now; a response arriving now is already accounted for.
      fpc_d   = redirect_pc & ~WIDTH'(3);
      rpc_d   = redirect_pc & ~WIDTH'(3);
      drop_d  = infl_d;
      wp_d    = '0;
      rp_d    = '0;
      cnt_d   = '0;
      state_d = (infl_d != '0) ? S_FLUSH : S_FETCH;
    end else begin
      if (req_fire)
        fpc_d = fpc_q + WIDTH'(4);
      if (mem_rsp_valid && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (push) begin
        wp_d  = wp_q + AW'(1);
        rpc_d = rpc_q + WIDTH'(4);
      end
`ifdef IFU32_BYPASS_EN
      else if (rsp_keep)
        rpc_d = rpc_q + WIDTH'(4);
`endif
      if (pop)
        rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if ((state_q == S_FLUSH) && (drop_d == '0))
        state_d = S_FETCH;
    end
  end

  // Control state with synchronous active-low reset; reset beats redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      fpc_q   <= PC_START;
      rpc_q   <= PC_START;
      infl_q  <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // FIFO storage; contents are only visible through cnt_q so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wp_q] <= mem_rsp_data;
      fifo_pc_q[wp_q]   <= rpc_q;
    end
  end

`ifndef SYNTHESIS
  // Responses must match an outstanding request and never hit a full FIFO.
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst)
    mem_rsp_valid |-> (infl_q != '0));
  a_rsp_not_full: assert property (@(posedge clk) disable iff (!rst)
    rsp_keep |-> (cnt_q != FULL_W));
`endif

endmodule

// File: tb/tb_ifu32_fetch.sv
// Testbench for ifu32_fetch: cycle table, reset-in-flight sequence and a
// randomised memory/redirect stress run against a simple PC-sequence model.
module tb_ifu32_fetch;
  localparam logic [31:0] B = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, mem_req_ready, mem_rsp_valid, inst_ready;
  logic [31:0] redirect_pc, mem_rsp_data;
  logic        mem_req_valid, inst_valid;
  logic [31:0] mem_req_addr, inst, inst_pc;

  always #5 clk = ~clk;

  ifu32_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  int n_chk = 0, n_fail = 0;

  function automatic logic [31:0] md(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic r, rdv; logic [31:0] rdpc;
    logic rqr, rsv; logic [31:0] rsd; logic ir;
    logic e_rqv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_inst, e_pc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic rdv, input logic [31:0] rdpc,
                     input logic rqr, input logic rsv, input logic [31:0] rsd, input logic ir,
                     input logic e_rqv, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.r = r; v.rdv = rdv; v.rdpc = rdpc; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd; v.ir = ir;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  initial begin
    // 1-cycle memory, hand-computed per cycle:
    //   r rdv rdpc        rqr rsv rsd            ir  e_rqv e_addr    e_iv e_inst        e_pc
    add(0,0,0,           0,0,0,               0,  0,B,          0,0,0);
    add(1,0,0,           1,0,0,               1,  1,B,          0,0,0);
    add(1,0,0,           1,1,md(B),           1,  1,B+4,        0,0,0);
    add(1,0,0,           1,1,md(B+4),         1,  0,B+8,        1,md(B),B);
    add(1,0,0,           1,0,0,               1,  1,B+8,        1,md(B+4),B+4);
    add(1,0,0,           1,1,md(B+8),         1,  1,B+'hc,      0,0,0);
    add(1,0,0,           1,1,md(B+'hc),       0,  0,B+'h10,     1,md(B+8),B+8);
    add(1,0,0,           1,0,0,               0,  0,B+'h10,     1,md(B+8),B+8);
    add(1,0,0,           1,0,0,               0,  0,B+'h10,     1,md(B+8),B+8);
    add(1,0,0,           1,0,0,               1,  0,B+'h10,     1,md(B+8),B+8);
    add(1,0,0,           1,0,0,               1,  1,B+'h10,     1,md(B+'hc),B+'hc);
    add(1,0,0,           1,1,md(B+'h10),      1,  1,B+'h14,     0,0,0);
    // redirect coincident with a response: response dropped, unaligned target
    add(1,1,B+'h102,     1,1,md(B+'h14),      0,  0,B+'h18,     1,md(B+'h10),B+'h10);
    add(1,0,0,           1,0,0,               1,  1,B+'h100,    0,0,0);
    // redirect coincident with a request fire: two stale responses to drop
    add(1,1,B+'h200,     1,0,0,               1,  1,B+'h104,    0,0,0);
    add(1,0,0,           1,1,md(B+'h100),     1,  0,B+'h200,    0,0,0);
    add(1,0,0,           1,1,md(B+'h104),     1,  0,B+'h200,    0,0,0);
    add(1,0,0,           1,0,0,               1,  1,B+'h200,    0,0,0);
    add(1,0,0,           0,1,md(B+'h200),     0,  1,B+'h204,    0,0,0);
    add(1,0,0,           0,0,0,               0,  1,B+'h204,    1,md(B+'h200),B+'h200);
    add(0,0,0,           0,0,0,               0,  0,B+'h204,    1,md(B+'h200),B+'h200);
    add(0,0,0,           0,0,0,               0,  0,B,          0,0,0);
    add(1,0,0,           0,0,0,               0,  1,B,          0,0,0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; redirect_valid = tbl[i].rdv; redirect_pc = tbl[i].rdpc;
      mem_req_ready = tbl[i].rqr; mem_rsp_valid = tbl[i].rsv; mem_rsp_data = tbl[i].rsd;
      inst_ready = tbl[i].ir;
      #1;
      chk($sformatf("v%0d req_valid", i), {31'b0, mem_req_valid}, {31'b0, tbl[i].e_rqv});
      chk($sformatf("v%0d req_addr", i), mem_req_addr, tbl[i].e_addr);
      chk($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
      if (tbl[i].e_iv || !tbl[i].r) begin
        chk($sformatf("v%0d inst", i), inst, tbl[i].e_inst);
        chk($sformatf("v%0d inst_pc", i), inst_pc, tbl[i].e_pc);
      end
    end

    // Reset with two requests in flight; redirect and response during reset ignored.
    do_reset();
    @(negedge clk); rst = 1'b1; mem_req_ready = 1'b1; #1;
    chk("b_req0_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("b_req0_addr", mem_req_addr, B);
    @(negedge clk); #1;
    chk("b_req1_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("b_req1_addr", mem_req_addr, B+4);
    @(negedge clk); #1;
    chk("b_depth_limit", {31'b0, mem_req_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = md(B);
    redirect_valid = 1'b1; redirect_pc = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b1; mem_rsp_valid = 1'b0; redirect_valid = 1'b0; #1;
    chk("b_rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("b_rst_req_addr", mem_req_addr, B);
    chk("b_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("b_rst_inst", inst, 32'd0);
    chk("b_rst_inst_pc", inst_pc, 32'd0);
    @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = md(B); #1;
    chk("b_lat_inst_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk); mem_rsp_valid = 1'b0; #1;
    chk("b_restart_valid", {31'b0, inst_valid}, 32'd1);
    chk("b_restart_pc", inst_pc, B);
    chk("b_restart_inst", inst, md(B));

    // Random ready/latency/redirect stress against an expected-PC model.
    do_reset();
    begin
      logic [31:0] exp_pc, paddr;
      logic pv, pr, prd;
      int got, last_due;
      exp_pc = B; got = 0; last_due = -1; pv = 1'b0; pr = 1'b0; prd = 1'b0; paddr = '0;
      mq.delete();
      for (int cyc = 0; cyc < 30000 && got < 1000; cyc++) begin
        @(negedge clk);
        rst = 1'b1;
        mem_req_ready  = ($urandom_range(1, 0) == 1);
        inst_ready     = ($urandom_range(3, 0) != 0);
        redirect_valid = ($urandom_range(63, 0) == 0);
        redirect_pc    = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF9 : $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          mem_rsp_valid = 1'b1; mem_rsp_data = md(mq[0].addr);
        end else begin
          mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        end
        #1;
        if (pv && !pr && !prd) begin
          chk("s_req_hold", {31'b0, mem_req_valid}, 32'd1);
          chk("s_req_hold_addr", mem_req_addr, paddr);
        end
        if (mem_req_valid && mem_req_ready) begin
          mreq_t m;
          int d;
          d = cyc + int'($urandom_range(4, 1));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          m.addr = mem_req_addr; m.due = d;
          mq.push_back(m);
          chk("s_addr_align", {30'b0, mem_req_addr[1:0]}, 32'd0);
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          chk("s_inst_pc", inst_pc, exp_pc);
          chk("s_inst", inst, md(exp_pc));
          exp_pc = exp_pc + 32'd4;
          got++;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
        if (mem_rsp_valid) void'(mq.pop_front());
        pv = mem_req_valid; pr = mem_req_ready; prd = redirect_valid; paddr = mem_req_addr;
      end
      chk("s_instr_count", got, 32'd1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
